// File: rtl/snd_pkg.sv
// Shared types and default timing constants for the sound-command scheduler.
// The IRQ/gap defaults match the 8 MHz sound clock generator.
package snd_pkg;

    localparam int IRQ_DIV_DEF = 33334;
    localparam int GAP_CYC_DEF = 64;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_WAIT_ACK = 3'd2,
        S_WAIT_RD  = 3'd3,
        S_GAP      = 3'd4
    } state_e;

endpackage

// File: rtl/sndcmd_scheduler_if.sv
// Game-side request and sound-Z80-side handshake bundle.
// The master drives requests and Z80 acknowledges; the scheduler is the slave.
interface sndcmd_scheduler_if #(
    parameter int FIFO_AW = 2
);
    logic [7:0]       sndno;
    logic             sndstart;
    logic             cpu_nmi;
    logic             cpu_nmia;
    logic             cpu_irq;
    logic             cpu_irqa;
    logic             com_rd;
    logic [7:0]       comlatch;
    logic [FIFO_AW:0] fifo_lvl;
    logic             busy;
    logic             ovf;

    modport master (
        output sndno, sndstart, cpu_nmia, cpu_irqa, com_rd,
        input  cpu_nmi, cpu_irq, comlatch, fifo_lvl, busy, ovf
    );

    modport slave (
        input  sndno, sndstart, cpu_nmia, cpu_irqa, com_rd,
        output cpu_nmi, cpu_irq, comlatch, fifo_lvl, busy, ovf
    );

endinterface

// File: rtl/sndcmd_fifo.sv
// Small synchronous command FIFO with registered count and fall-through head.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sndcmd_fifo #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk8M,
    input  logic          reset_n,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam int DEPTH = 1 << AW;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] mem_d [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic          do_push, do_pop;

    assign full    = (cnt_q == FULL_CNT);
    assign empty   = (cnt_q == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout    = mem_q[rptr_q];
    assign level   = cnt_q;

    always_comb begin
        mem_d  = mem_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        if (do_push) begin
            mem_d[wptr_q] = din;
            wptr_d        = wptr_q + AW'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + AW'(1);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + (AW+1)'(1);
            2'b01:   cnt_d = cnt_q - (AW+1)'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            mem_q  <= '{default: '0};
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            mem_q  <= mem_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
        end
    end

endmodule

// File: rtl/sndcmd_scheduler.sv
// Delivers queued sound codes to the sound Z80 one at a time via latch + NMI,
// and generates the free-running periodic sound-CPU IRQ.
import snd_pkg::*;

module sndcmd_scheduler #(
    parameter int FIFO_AW = 2,
    parameter int IRQ_DIV = IRQ_DIV_DEF,
    parameter int GAP_CYC = GAP_CYC_DEF
) (
    input  logic               clk8M,
    input  logic               reset_n,
    sndcmd_scheduler_if.slave  bus
);

    localparam int TW = $clog2(IRQ_DIV);
    localparam int GW = $clog2(GAP_CYC);
    localparam logic [TW-1:0] T_LAST = TW'(IRQ_DIV - 1);
    localparam logic [GW-1:0] G_LOAD = GW'(GAP_CYC - 1);

    state_e           state_q, state_d;
    logic [GW-1:0]    gap_q, gap_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             start_q, start_d;
    logic             nmi_q, nmi_d;
    logic             irq_q, irq_d;
    logic             ovf_q, ovf_d;
    logic [7:0]       latch_q, latch_d;

    logic             push, pop;
    logic             fifo_full, fifo_empty;
    logic [7:0]       fifo_dout;
    logic [FIFO_AW:0] fifo_lvl;

    sndcmd_fifo #(
        .DW (8),
        .AW (FIFO_AW)
    ) u_fifo (
        .clk8M   (clk8M),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .din     (bus.sndno),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_lvl)
    );

    assign start_d = bus.sndstart;
    assign push    = bus.sndstart & ~start_q;
    assign ovf_d   = ovf_q | (push & fifo_full & ~pop);

    always_comb begin
        state_d = state_q;
        gap_d   = gap_q;
        nmi_d   = nmi_q;
        latch_d = latch_q;
        pop     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                pop     = 1'b1;
                latch_d = fifo_dout;
                nmi_d   = 1'b1;
                state_d = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                // An early latch read skips the ack and retires the command
                if (bus.com_rd) begin
                    nmi_d   = 1'b0;
                    gap_d   = G_LOAD;
                    state_d = S_GAP;
                end else if (bus.cpu_nmia) begin
                    nmi_d   = 1'b0;
                    state_d = S_WAIT_RD;
                end
            end
            S_WAIT_RD: begin
                if (bus.com_rd) begin
                    gap_d   = G_LOAD;
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (gap_q == '0) state_d = S_IDLE;
                else             gap_d   = gap_q - GW'(1);
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        timer_d = (timer_q == T_LAST) ? '0 : timer_q + TW'(1);
        irq_d   = irq_q;
        if (timer_q == T_LAST) irq_d = 1'b1;
        else if (bus.cpu_irqa) irq_d = 1'b0;
    end

    always_ff @(posedge clk8M or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gap_q   <= '0;
            timer_q <= '0;
            start_q <= 1'b0;
            nmi_q   <= 1'b0;
            irq_q   <= 1'b0;
            ovf_q   <= 1'b0;
            latch_q <= 8'h00;
        end else begin
            state_q <= state_d;
            gap_q   <= gap_d;
            timer_q <= timer_d;
            start_q <= start_d;
            nmi_q   <= nmi_d;
            irq_q   <= irq_d;
            ovf_q   <= ovf_d;
            latch_q <= latch_d;
        end
    end

    assign bus.cpu_nmi  = nmi_q;
    assign bus.cpu_irq  = irq_q;
    assign bus.comlatch = latch_q;
    assign bus.fifo_lvl = fifo_lvl;
    assign bus.busy     = (state_q != S_IDLE);
    assign bus.ovf      = ovf_q;

endmodule
